// File: rtl/booth_prod_accum.sv
// Frame accumulator for signed Booth products: sums LEN products per frame into an AW-bit result.
// Optional `PROD_ACC_SAT_EN: saturating adds instead of wrap-around (overflow flag reported either way).
module booth_prod_accum #(
   parameter int unsigned PW  = 16,
   parameter int unsigned AW  = 24,
   parameter int unsigned LEN = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_p,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_sum,
   output logic          out_ovf
);

   localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CW-1:0] CntLast = CW'(LEN - 1);

   if (AW <= PW) begin : g_bad_width
      $error("booth_prod_accum: AW must exceed PW");
   end

   typedef enum logic {StAcc, StOut} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          flag_q, flag_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [AW-1:0] out_sum_q, out_sum_d;
   logic          out_ovf_q, out_ovf_d;

   logic [AW-1:0] p_ext;
   logic [AW-1:0] sum_raw;
   logic [AW-1:0] sum_new;
   logic          add_ovf;
   logic          in_xfer;
   logic          out_xfer;

   assign p_ext    = {{(AW-PW){in_p[PW-1]}}, in_p};
   assign sum_raw  = acc_q + p_ext;
   assign add_ovf  = (acc_q[AW-1] == p_ext[AW-1]) && (sum_raw[AW-1] != acc_q[AW-1]);
   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = out_valid_q & out_ready;

`ifdef PROD_ACC_SAT_EN
   // On overflow both operands share a sign, so the accumulator's sign picks the rail.
   always_comb begin
      sum_new = sum_raw;
      if (add_ovf) begin
         sum_new = acc_q[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end
   end
`else
   assign sum_new = sum_raw;
`endif

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      flag_d      = flag_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_ovf_d   = out_ovf_q;

      if (clr) begin
         state_d     = StAcc;
         acc_d       = '0;
         cnt_d       = '0;
         flag_d      = 1'b0;
         out_valid_d = 1'b0;
         in_ready_d  = 1'b1;
      end else begin
         unique case (state_q)
            StAcc: begin
               // Also raises in_ready on the first edge after reset release.
               in_ready_d = 1'b1;
               if (in_xfer) begin
                  acc_d  = sum_new;
                  flag_d = flag_q | add_ovf;
                  if (cnt_q == CntLast) begin
                     cnt_d       = '0;
                     out_sum_d   = sum_new;
                     out_ovf_d   = flag_q | add_ovf;
                     out_valid_d = 1'b1;
                     in_ready_d  = 1'b0;
                     state_d     = StOut;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            StOut: begin
               in_ready_d = 1'b0;
               if (out_xfer) begin
                  out_valid_d = 1'b0;
                  acc_d       = '0;
                  cnt_d       = '0;
                  flag_d      = 1'b0;
                  in_ready_d  = 1'b1;
                  state_d     = StAcc;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StAcc;
         acc_q       <= '0;
         cnt_q       <= '0;
         flag_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         flag_q      <= flag_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_booth_prod_accum.sv
// Bench for booth_prod_accum: a 24-bit and a 17-bit instance share one input stream and are
// compared against an integer-arithmetic frame model, plus directed handshake/reset/clear cases.
module tb_booth_prod_accum;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] in_p = '0;

   logic        in_ready_a, out_valid_a, out_ovf_a;
   logic [23:0] out_sum_a;
   logic        in_ready_b, out_valid_b, out_ovf_b;
   logic [16:0] out_sum_b;

   int n_pass = 0;
   int n_chk  = 0;

`ifdef PROD_ACC_SAT_EN
   localparam bit Sat = 1'b1;
`else
   localparam bit Sat = 1'b0;
`endif

   booth_prod_accum #(.PW(16), .AW(24), .LEN(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_p(in_p), .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
      .out_ovf(out_ovf_a)
   );

   booth_prod_accum #(.PW(16), .AW(17), .LEN(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_p(in_p), .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
      .out_ovf(out_ovf_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] p [8];
      logic [23:0] sum;
      bit          ovf;
   } vec_t;

   vec_t        tbl [7];
   logic [15:0] frame [8];

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Running sum with exact integers; out-of-range steps flag overflow then wrap or clamp.
   function automatic void model(input int aw, output longint s, output bit ovf);
      longint mx = (longint'(1) <<< (aw - 1)) - 1;
      longint mn = -mx - 1;
      longint m  = longint'(1) <<< aw;
      s   = 0;
      ovf = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s += longint'($signed(frame[i]));
         if (s > mx) begin
            ovf = 1'b1;
            s   = Sat ? mx : s - m;
         end else if (s < mn) begin
            ovf = 1'b1;
            s   = Sat ? mn : s + m;
         end
      end
   endfunction

   // All tasks start and end right after a falling edge.
   task automatic send(input logic [15:0] p);
      int t = 0;
      in_valid = 1'b1;
      in_p     = p;
      while (!in_ready_a && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("send_timeout", longint'(in_ready_a), 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_p     = 'x;
   endtask

   task automatic send_frame(input int gaps);
      for (int i = 0; i < 8; i++) begin
         if (gaps > 0) repeat ($urandom_range(0, gaps)) @(negedge clk);
         send(frame[i]);
      end
   endtask

   task automatic wait_out();
      int t = 0;
      while (!out_valid_a && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("wait_out_timeout", longint'(out_valid_a), 1);
   endtask

   task automatic take(input string name, input longint e24, input bit o24, input longint e17,
                       input bit o17, input int delay);
      out_ready = 1'b0;
      wait_out();
      repeat (delay) @(negedge clk);
      check({name, "_sum24"}, longint'($signed(out_sum_a)), e24);
      check({name, "_ovf24"}, longint'(out_ovf_a), longint'(o24));
      check({name, "_sum17"}, longint'($signed(out_sum_b)), e17);
      check({name, "_ovf17"}, longint'(out_ovf_b), longint'(o17));
      check({name, "_valid17"}, longint'(out_valid_b), 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_drained"}, longint'(out_valid_a), 0);
      check({name, "_ready_back"}, longint'(in_ready_a), 1);
   endtask

   task automatic take_model(input string name, input int delay);
      longint s24, s17;
      bit     o24, o17;
      model(24, s24, o24);
      model(17, s17, o17);
      take(name, s24, o24, s17, o17, delay);
   endtask

   initial begin
      tbl[0].name = "t1_0100";  tbl[0].p = '{default: 16'h0100}; tbl[0].sum = 24'h000800;
      tbl[0].ovf  = 1'b0;
      tbl[1].name = "t2_alt";
      tbl[1].p = '{16'h03E8, 16'hFC18, 16'h03E8, 16'hFC18, 16'h03E8, 16'hFC18, 16'h03E8, 16'hFC18};
      tbl[1].sum  = 24'h000000; tbl[1].ovf = 1'b0;
      tbl[2].name = "all_ffff"; tbl[2].p = '{default: 16'hFFFF}; tbl[2].sum = 24'hFFFFF8;
      tbl[2].ovf  = 1'b0;
      tbl[3].name = "all_0001"; tbl[3].p = '{default: 16'h0001}; tbl[3].sum = 24'h000008;
      tbl[3].ovf  = 1'b0;
      tbl[4].name = "all_7fff"; tbl[4].p = '{default: 16'h7FFF}; tbl[4].sum = 24'h03FFF8;
      tbl[4].ovf  = 1'b0;
      tbl[5].name = "all_8000"; tbl[5].p = '{default: 16'h8000}; tbl[5].sum = 24'hFC0000;
      tbl[5].ovf  = 1'b0;
      tbl[6].name = "pow2";
      tbl[6].p = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080};
      tbl[6].sum  = 24'h0000FF; tbl[6].ovf = 1'b0;

      // Reset state and in_ready rising one edge after release.
      #1;
      check("rst_out_valid", longint'(out_valid_a), 0);
      check("rst_out_sum", longint'(out_sum_a), 0);
      check("rst_out_ovf", longint'(out_ovf_a), 0);
      check("rst_in_ready", longint'(in_ready_a), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 check("rel_in_ready_low", longint'(in_ready_a), 0);
      @(negedge clk);
      check("rel_in_ready_high", longint'(in_ready_a), 1);

      // Table-driven frames; result must appear one clock after the last transfer.
      for (int k = 0; k < 7; k++) begin
         longint s17;
         bit     o17;
         frame = tbl[k].p;
         model(17, s17, o17);
         send_frame(0);
         check({tbl[k].name, "_latency"}, longint'(out_valid_a), 1);
         check({tbl[k].name, "_in_ready_low"}, longint'(in_ready_a), 0);
         take(tbl[k].name, longint'($signed(tbl[k].sum)), tbl[k].ovf, s17, o17, 0);
      end

      // T4: 17-bit overflow, wrap vs clamp.
      frame = '{default: 16'h7FFF};
      send_frame(0);
      take("t4", 262136, 1'b0, Sat ? 65535 : -8, 1'b1, 0);

      // T3: result held under backpressure, inputs ignored while holding.
      frame = '{default: 16'h0100};
      send_frame(0);
      in_valid = 1'b1;
      in_p     = 16'h7777;
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_valid", longint'(out_valid_a), 1);
         check("t3_hold_sum", longint'(out_sum_a), 2048);
         check("t3_hold_in_ready", longint'(in_ready_a), 0);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("t3_released_valid", longint'(out_valid_a), 0);
      check("t3_released_in_ready", longint'(in_ready_a), 1);
      send_frame(0);
      take("t3_next", 2048, 1'b0, 2048, 1'b0, 0);

      // T5: async reset mid-frame and while a result is held.
      for (int i = 0; i < 3; i++) send(16'h0010);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_valid", longint'(out_valid_a), 0);
      check("t5_rst_sum", longint'(out_sum_a), 0);
      check("t5_rst_in_ready", longint'(in_ready_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(0);
      wait_out();
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_held_valid", longint'(out_valid_a), 0);
      check("t5_rst_held_sum", longint'(out_sum_a), 0);
      check("t5_rst_held_ovf17", longint'(out_ovf_b), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      frame = '{default: 16'h0001};
      send_frame(0);
      take("t5_after", 8, 1'b0, 8, 1'b0, 0);

      // T6: clr mid-frame, with a same-cycle input that must be discarded.
      for (int i = 0; i < 5; i++) send(16'h8000);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_p     = 16'h1234;
      @(negedge clk);
      clr      = 1'b0;
      in_valid = 1'b0;
      frame    = '{default: 16'hFFFF};
      send_frame(0);
      take("t6", -8, 1'b0, -8, 1'b0, 0);

      // clr while a result is held: valid drops, sum stays, accumulation restarts.
      frame = '{default: 16'h0100};
      send_frame(0);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_out_valid", longint'(out_valid_a), 0);
      check("clr_out_sum_kept", longint'(out_sum_a), 2048);
      check("clr_in_ready", longint'(in_ready_a), 1);
      frame = '{default: 16'h0001};
      send_frame(0);
      take("clr_after", 8, 1'b0, 8, 1'b0, 0);

      // Random frames with input gaps and output backpressure.
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < 8; i++) begin
            if (k % 2 == 0) frame[i] = 16'($urandom);
            else frame[i] = $urandom_range(0, 1) ? 16'($urandom_range(16'h7000, 16'h7FFF))
                                                 : 16'($urandom_range(16'h8000, 16'h8FFF));
         end
         send_frame(2);
         take_model($sformatf("rand%0d", k), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
